// File: rtl/shapool_pkg.sv
// Shared definitions for the shapool scheduler: FSM state encoding and
// width helpers derived from the top-level parameters.
package shapool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic int rounds_log2(input int rounds);
        return $clog2(rounds);
    endfunction

    function automatic int local_width(input int nonce_width, input int pool_size_log2);
        return nonce_width - pool_size_log2;
    endfunction

endpackage

// File: rtl/shapool_round_counter.sv
// Round index counter for one hash window: enable, synchronous clear and a
// flag marking the last round of the window.
module shapool_round_counter #(
    parameter int ROUNDS = 64,
    parameter int W      = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count,
    output logic         o_window_end
);

    logic [W-1:0] r_count;

    // Round counter; wraps naturally because ROUNDS is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= {W{1'b0}};
        end else if (i_clr) begin
            r_count <= {W{1'b0}};
        end else if (i_en) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count      = r_count;
    assign o_window_end = (r_count == W'(ROUNDS - 1));

endmodule

// File: rtl/shapool_scheduler.sv
// Sequences the shapool hashing pipeline: primes the pool, steps the local
// nonce once per window, and reports the corrected winning nonce or exhaustion.
module shapool_scheduler
    import shapool_pkg::*;
#(
    parameter int NONCE_WIDTH    = 32,
    parameter int POOL_SIZE_LOG2 = 2,
    parameter int ROUNDS         = 64
) (
    input  logic                                                clk,
    input  logic                                                reset,
    input  logic                                                start,
    input  logic                                                halt,
    input  logic [local_width(NONCE_WIDTH, POOL_SIZE_LOG2)-1:0] nonce_init,
    input  logic                                                shapool_success,
    output logic                                                shapool_clear,
    output logic [rounds_log2(ROUNDS)-1:0]                      round_idx,
    output logic [local_width(NONCE_WIDTH, POOL_SIZE_LOG2)-1:0] nonce,
    output logic                                                busy,
    output logic                                                done,
    output logic                                                result_valid,
    output logic [local_width(NONCE_WIDTH, POOL_SIZE_LOG2)-1:0] result_nonce,
    output logic                                                exhausted
);

    localparam int LW = local_width(NONCE_WIDTH, POOL_SIZE_LOG2);
    localparam int RL = rounds_log2(ROUNDS);

    state_t          r_state;
    logic [LW-1:0]   r_nonce;
    logic [LW-1:0]   r_result_nonce;
    logic            r_result_valid;
    logic            r_exhausted;
    logic            r_clear;
    logic            r_busy;
    logic            r_done;

    state_t          w_state_nxt;
    logic [LW-1:0]   w_nonce_nxt;
    logic [LW-1:0]   w_result_nonce_nxt;
    logic            w_result_valid_nxt;
    logic            w_exhausted_nxt;
    logic            w_clear_nxt;
    logic            w_cnt_clr;
    logic            w_window_end;
    logic            w_nonce_last;
    logic [RL-1:0]   w_round;

    shapool_round_counter #(
        .ROUNDS (ROUNDS),
        .W      (RL)
    ) u_round_counter (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (w_cnt_clr),
        .i_en         (r_busy),
        .o_count      (w_round),
        .o_window_end (w_window_end)
    );

    assign w_nonce_last = (r_nonce == {LW{1'b1}});

    // Next-state and result capture; a window-end success beats halt, halt beats window rollover.
    always_comb begin
        w_state_nxt        = r_state;
        w_nonce_nxt        = r_nonce;
        w_result_nonce_nxt = r_result_nonce;
        w_result_valid_nxt = r_result_valid;
        w_exhausted_nxt    = r_exhausted;
        w_clear_nxt        = 1'b0;
        w_cnt_clr          = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt        = ST_PRIME;
                    w_nonce_nxt        = nonce_init;
                    w_result_nonce_nxt = {LW{1'b0}};
                    w_result_valid_nxt = 1'b0;
                    w_exhausted_nxt    = 1'b0;
                    w_clear_nxt        = 1'b1;
                    w_cnt_clr          = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_PRIME: begin
                if (halt) begin
                    w_state_nxt = ST_DONE;
                end else if (w_window_end && w_nonce_last) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_window_end) begin
                    w_state_nxt = ST_RUN;
                    w_nonce_nxt = r_nonce + LW'(1);
                end else begin
                    w_state_nxt = ST_PRIME;
                end
            end
            ST_RUN: begin
                // The pool reports one window late, so the winner is the previous nonce.
                if (w_window_end && shapool_success) begin
                    w_state_nxt        = ST_DONE;
                    w_result_valid_nxt = 1'b1;
                    w_result_nonce_nxt = r_nonce - LW'(1);
                end else if (halt) begin
                    w_state_nxt = ST_DONE;
                end else if (w_window_end && w_nonce_last) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_window_end) begin
                    w_nonce_nxt = r_nonce + LW'(1);
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (w_window_end && shapool_success) begin
                    w_state_nxt        = ST_DONE;
                    w_result_valid_nxt = 1'b1;
                    w_result_nonce_nxt = r_nonce;
                end else if (halt) begin
                    w_state_nxt = ST_DONE;
                end else if (w_window_end) begin
                    w_state_nxt     = ST_DONE;
                    w_exhausted_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, nonce, result and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_nonce        <= {LW{1'b0}};
            r_result_nonce <= {LW{1'b0}};
            r_result_valid <= 1'b0;
            r_exhausted    <= 1'b0;
            r_clear        <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_nonce        <= w_nonce_nxt;
            r_result_nonce <= w_result_nonce_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_exhausted    <= w_exhausted_nxt;
            r_clear        <= w_clear_nxt;
            r_busy         <= (w_state_nxt == ST_PRIME) || (w_state_nxt == ST_RUN) ||
                              (w_state_nxt == ST_DRAIN);
            r_done         <= (w_state_nxt == ST_DONE);
        end
    end

    assign shapool_clear = r_clear;
    assign round_idx     = w_round;
    assign nonce         = r_nonce;
    assign busy          = r_busy;
    assign done          = r_done;
    assign result_valid  = r_result_valid;
    assign result_nonce  = r_result_nonce;
    assign exhausted     = r_exhausted;

endmodule

// File: tb/tb_shapool_scheduler.sv
// Directed bench for shapool_scheduler: cycle-numbered jobs with hand-computed
// expectations (cycle 0 = the cycle in which start is high).
module tb_shapool_scheduler;

    logic        clk;
    logic        reset;
    logic        start;
    logic        halt;
    logic [29:0] nonce_init;
    logic        shapool_success;
    logic        shapool_clear;
    logic [5:0]  round_idx;
    logic [29:0] nonce;
    logic        busy;
    logic        done;
    logic        result_valid;
    logic [29:0] result_nonce;
    logic        exhausted;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    shapool_scheduler #(
        .NONCE_WIDTH    (32),
        .POOL_SIZE_LOG2 (2),
        .ROUNDS         (64)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .halt            (halt),
        .nonce_init      (nonce_init),
        .shapool_success (shapool_success),
        .shapool_clear   (shapool_clear),
        .round_idx       (round_idx),
        .nonce           (nonce),
        .busy            (busy),
        .done            (done),
        .result_valid    (result_valid),
        .result_nonce    (result_nonce),
        .exhausted       (exhausted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic start_job(input logic [29:0] v);
        nonce_init = v;
        start      = 1'b1;
        cyc        = 0;
        step();
        start      = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic b, input logic d,
                              input logic rv, input logic ex);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, b});
        chk({tag, "_done"}, {31'd0, done}, {31'd0, d});
        chk({tag, "_rv"},   {31'd0, result_valid}, {31'd0, rv});
        chk({tag, "_exh"},  {31'd0, exhausted}, {31'd0, ex});
    endtask

    initial begin
        reset           = 1'b1;
        start           = 1'b1;
        halt            = 1'b0;
        nonce_init      = 30'h0000_0010;
        shapool_success = 1'b0;

        // Reset with start held high: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_status("rst", 1'b0, 1'b0, 1'b0, 1'b0);
            chk("rst_clear", {31'd0, shapool_clear}, 32'd0);
            chk("rst_round", {26'd0, round_idx}, 32'd0);
            chk("rst_nonce", {2'd0, nonce}, 32'd0);
            chk("rst_rnonce", {2'd0, result_nonce}, 32'd0);
        end
        reset = 1'b0;
        start = 1'b0;
        step();
        chk_status("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        halt = 1'b1;
        step();
        chk_status("idle_halt", 1'b0, 1'b0, 1'b0, 1'b0);
        halt = 1'b0;

        // Job 1: success at end of second RUN window -> nonce 0x11.
        start_job(30'h0000_0010);
        chk("j1_clear1", {31'd0, shapool_clear}, 32'd1);
        chk("j1_round1", {26'd0, round_idx}, 32'd0);
        chk("j1_nonce1", {2'd0, nonce}, 32'h10);
        chk_status("j1_c1", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk("j1_clear2", {31'd0, shapool_clear}, 32'd0);
        goto(64);
        chk("j1_round64", {26'd0, round_idx}, 32'd63);
        shapool_success = 1'b1;
        step();
        shapool_success = 1'b0;
        chk("j1_prime_succ_ign", {31'd0, busy}, 32'd1);
        chk("j1_nonce65", {2'd0, nonce}, 32'h11);
        chk("j1_round65", {26'd0, round_idx}, 32'd0);
        goto(70);
        nonce_init = 30'h0000_0555;
        start      = 1'b1;
        step();
        start      = 1'b0;
        chk("j1_restart_ign_round", {26'd0, round_idx}, 32'd6);
        chk("j1_restart_ign_nonce", {2'd0, nonce}, 32'h11);
        chk("j1_restart_ign_clear", {31'd0, shapool_clear}, 32'd0);
        goto(129);
        chk("j1_nonce129", {2'd0, nonce}, 32'h12);
        goto(192);
        chk("j1_round192", {26'd0, round_idx}, 32'd63);
        shapool_success = 1'b1;
        step();
        shapool_success = 1'b0;
        chk_status("j1_c193", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("j1_rnonce", {2'd0, result_nonce}, 32'h11);
        halt = 1'b1;
        goto(200);
        halt = 1'b0;
        chk_status("j1_hold", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("j1_rnonce_hold", {2'd0, result_nonce}, 32'h11);

        // Job 2: restart from DONE at the top of the nonce space, no success.
        start_job(30'h3FFF_FFFF);
        chk_status("j2_c1", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("j2_rnonce_clr", {2'd0, result_nonce}, 32'd0);
        chk("j2_clear1", {31'd0, shapool_clear}, 32'd1);
        goto(65);
        chk("j2_drain_busy", {31'd0, busy}, 32'd1);
        chk("j2_drain_nonce", {2'd0, nonce}, 32'h3FFF_FFFF);
        goto(128);
        chk_status("j2_c128", 1'b1, 1'b0, 1'b0, 1'b0);
        step();
        chk_status("j2_c129", 1'b0, 1'b1, 1'b0, 1'b1);
        chk("j2_nonce129", {2'd0, nonce}, 32'h3FFF_FFFF);

        // Job 3: halt in RUN.
        start_job(30'h0000_0010);
        chk_status("j3_c1", 1'b1, 1'b0, 1'b0, 1'b0);
        goto(100);
        chk("j3_round100", {26'd0, round_idx}, 32'd35);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk_status("j3_c101", 1'b0, 1'b1, 1'b0, 1'b0);

        // Job 4: success and halt together at a RUN window end.
        start_job(30'h0000_0010);
        goto(128);
        chk("j4_nonce128", {2'd0, nonce}, 32'h11);
        chk("j4_round128", {26'd0, round_idx}, 32'd63);
        shapool_success = 1'b1;
        halt            = 1'b1;
        step();
        shapool_success = 1'b0;
        halt            = 1'b0;
        chk_status("j4_c129", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("j4_rnonce", {2'd0, result_nonce}, 32'h10);

        // Job 5: success at the end of DRAIN reports the all-ones nonce.
        start_job(30'h3FFF_FFFF);
        goto(128);
        shapool_success = 1'b1;
        step();
        shapool_success = 1'b0;
        chk_status("j5_c129", 1'b0, 1'b1, 1'b1, 1'b0);
        chk("j5_rnonce", {2'd0, result_nonce}, 32'h3FFF_FFFF);

        // Job 6: halt during PRIME, then reset mid-job clears everything.
        start_job(30'h0000_0020);
        goto(10);
        halt = 1'b1;
        step();
        halt = 1'b0;
        chk_status("j6_prime_halt", 1'b0, 1'b1, 1'b0, 1'b0);
        start_job(30'h0000_0020);
        goto(5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_status("j6_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("j6_reset_nonce", {2'd0, nonce}, 32'd0);
        chk("j6_reset_round", {26'd0, round_idx}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
